// File: rtl/game_pkg.sv
// Shared game constants and player FSM encodings used by the movement and hit logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } player_state_t;

  localparam int         SCREEN_W           = 160;
  localparam logic [7:0] DEFAULT_SHIP_Y     = 8'd110;
  localparam int         DEFAULT_SHIP_W     = 8;
  localparam int         DEFAULT_MAX_HEALTH = 3;

  // True when pos lies in [left, left+width); widened to 9 bits so a span near 255 cannot wrap.
  function automatic logic in_span(input logic [7:0] pos, input logic [7:0] left,
                                   input logic [7:0] width);
    logic [8:0] pos_w;
    logic [8:0] left_w;
    pos_w   = {1'b0, pos};
    left_w  = {1'b0, left};
    in_span = (pos_w >= left_w) && (pos_w < (left_w + {1'b0, width}));
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Rate divider: down-counter that reloads after reaching zero; tick is high while the count is zero.
module tick_divider #(
  parameter int unsigned RELOAD = 24999999,
  localparam int         W      = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= W'(RELOAD);
    end else if (count == '0) begin
      count <= W'(RELOAD);
    end else begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/player_hit_handler.sv
// Detects enemy bullets striking the player ship, tracks health, invulnerability and game over.
// Optional build macro: HIT_FLASH_EN (ship blinks on each tick while invulnerable).
module player_hit_handler
  import game_pkg::*;
#(
  parameter logic [7:0] SHIP_Y       = DEFAULT_SHIP_Y,
  parameter int         SHIP_W       = DEFAULT_SHIP_W,
  parameter int         MAX_HEALTH   = DEFAULT_MAX_HEALTH,
  parameter int         INVULN_TICKS = 4,
  parameter int         TICK_DIV     = 24999999
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x_val_ship,
  input  logic [7:0] x_val_bullet,
  input  logic [7:0] y_val_bullet,
  input  logic       bullet_valid,
  output logic [1:0] health,
  output logic       hit,
  output logic       bullet_clear,
  output logic       game_over,
  output logic       ship_visible,
  output logic [1:0] state_dbg
);

  player_state_t state, state_nxt;
  logic [1:0]    health_nxt;
  logic          hit_nxt;
  logic          clear_nxt;
  logic [7:0]    invuln_cnt, invuln_nxt;
  logic          tick;
  logic          coll;

  tick_divider #(.RELOAD(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign coll = bullet_valid && (y_val_bullet == SHIP_Y)
             && in_span(x_val_bullet, x_val_ship, 8'(SHIP_W));

`ifdef HIT_FLASH_EN
  logic flash_vis, flash_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_ALIVE;
      health       <= 2'(MAX_HEALTH);
      hit          <= 1'b0;
      bullet_clear <= 1'b0;
      invuln_cnt   <= 8'd0;
    end else begin
      state        <= state_nxt;
      health       <= health_nxt;
      hit          <= hit_nxt;
      bullet_clear <= clear_nxt;
      invuln_cnt   <= invuln_nxt;
    end
  end

`ifdef HIT_FLASH_EN
  always_ff @(posedge clock) begin
    if (reset) flash_vis <= 1'b1;
    else       flash_vis <= flash_nxt;
  end
`endif

  // Collisions are only acted on from ALIVE; INVULN and DEAD ignore them entirely.
  always_comb begin
    state_nxt  = state;
    health_nxt = health;
    invuln_nxt = invuln_cnt;
    hit_nxt    = 1'b0;
    clear_nxt  = 1'b0;
`ifdef HIT_FLASH_EN
    flash_nxt  = flash_vis;
`endif
    case (state)
      ST_ALIVE: begin
        if (coll) begin
          hit_nxt   = 1'b1;
          clear_nxt = 1'b1;
          if (health > 2'd1) begin
            health_nxt = health - 2'd1;
            invuln_nxt = 8'(INVULN_TICKS);
            state_nxt  = ST_INVULN;
`ifdef HIT_FLASH_EN
            flash_nxt  = 1'b0;
`endif
          end else begin
            health_nxt = 2'd0;
            state_nxt  = ST_DEAD;
          end
        end
      end
      ST_INVULN: begin
        if (tick) begin
`ifdef HIT_FLASH_EN
          flash_nxt = ~flash_vis;
`endif
          if (invuln_cnt <= 8'd1) begin
            invuln_nxt = 8'd0;
            state_nxt  = ST_ALIVE;
`ifdef HIT_FLASH_EN
            flash_nxt  = 1'b1;
`endif
          end else begin
            invuln_nxt = invuln_cnt - 8'd1;
          end
        end
      end
      ST_DEAD: begin
        health_nxt = 2'd0;
      end
      default: begin
        state_nxt = ST_ALIVE;
      end
    endcase
  end

  assign game_over = (state == ST_DEAD);
  assign state_dbg = state;

`ifdef HIT_FLASH_EN
  assign ship_visible = (state != ST_DEAD) && flash_vis;
`else
  assign ship_visible = (state != ST_DEAD);
`endif

endmodule
